// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instr_memory, fills the IF/ID
// register with a valid/ready handshake, and handles redirects, halt and errors.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] addr,
  input  logic [31:0] inst_in,
  input  logic        pc_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        halted,
  output logic        fetch_err
);

  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;

  logic fire;
  logic can_load;
  logic redirect_ok;
  logic pc_ok;

  assign fire        = id_valid_q & id_ready;
  assign can_load    = ~id_valid_q | id_ready;
  assign redirect_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_ADDR);
  assign pc_ok       = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_inst_q  <= 32'h0;
      id_pc_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
    end
  end

  // Next state: a redirect outranks everything except the terminal error state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          state_d = redirect_ok ? ST_RUN : ST_ERR;
        end else if (can_load) begin
          if (!pc_en)      state_d = ST_HALT;
          else if (!pc_ok) state_d = ST_ERR;
        end
      end
      ST_HALT: begin
        if (redirect) state_d = redirect_ok ? ST_RUN : ST_ERR;
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    if (state_q == ST_ERR) begin
      id_valid_d = 1'b0;
    end else if (redirect) begin
      id_valid_d = 1'b0;
      if (redirect_ok) pc_d = redirect_pc;
    end else if (state_q == ST_RUN) begin
      if (can_load) begin
        if (pc_en) begin
          if (pc_ok) begin
            id_inst_d  = inst_in;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end else begin
            id_valid_d = 1'b0;
          end
        end else if (fire) begin
          id_valid_d = 1'b0;
        end
      end
    end else if (fire) begin
      // HALT: drain whatever is still sitting in IF/ID.
      id_valid_d = 1'b0;
    end
  end

  always_comb begin
    halted    = (state_q == ST_HALT);
    fetch_err = (state_q == ST_ERR);
  end

  assign addr     = pc_q;
  assign id_valid = id_valid_q;
  assign id_inst  = id_inst_q;
  assign id_pc    = id_pc_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage directly upstream of `instr_memory`. It owns the program counter, drives the fetch address into `instr_memory`, and takes back the fetched word and its `pc_en` halt flag. It registers the instruction and its PC into an IF/ID pipeline register with a valid/ready handshake toward decode. It also applies branch/jump redirects from execute and stops fetching on the all-zero halt word.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `IMEM_BYTES`, 1024, instruction-memory size in bytes. Legal fetch addresses are 0..`IMEM_BYTES`-4 and must be word-aligned.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  out  32  fetch address to `instr_memory.Addr`; equals the PC register.
- `inst_in`  in  32  word from `instr_memory.INST`, combinational from `addr`.
- `pc_en`  in  1  from `instr_memory`; 0 when `inst_in` == 32'h0000_0000 (halt word).
- `redirect`  in  1  taken branch/jump from execute; single-cycle pulse.
- `redirect_pc`  in  32  target PC, valid when `redirect`=1.
- `id_valid`  out  1  IF/ID register holds a valid instruction.
- `id_ready`  in  1  decode accepts the IF/ID contents this cycle.
- `id_inst`  out  32  registered instruction.
- `id_pc`  out  32  PC of `id_inst`.
- `halted`  out  1  1 while in HALT.
- `fetch_err`  out  1  sticky; set on a misaligned or out-of-range fetch address.

## Operation
The FSM has three states: RUN, HALT and ERR. Reset enters RUN.

Transfer rule: `fire` = `id_valid` & `id_ready`. The IF/ID register may load when `!id_valid | id_ready`.

Priority each cycle, highest first:

1. **`redirect`=1 (any state except ERR)**
   - Illegal target (`redirect_pc[1:0]`≠0, or `redirect_pc` > `IMEM_BYTES`-4): go to ERR, set `fetch_err`, clear `id_valid`, leave PC unchanged.
   - Legal target: PC <= `redirect_pc`, `id_valid` <= 0 (flush), state <= RUN. Leaves HALT.
2. **RUN, IF/ID can load, `pc_en`=1**
   - `id_inst` <= `inst_in`, `id_pc` <= PC, `id_valid` <= 1.
   - PC <= PC+4, computed in 32 bits (wraps modulo 2^32).
3. **RUN, IF/ID can load, `pc_en`=0**
   - Halt word: not captured. PC holds.
   - `id_valid` <= 0 if `fire`, else it holds.
   - state <= HALT.
4. **RUN, IF/ID cannot load (stall)**: PC, `id_inst`, `id_pc` and `id_valid` all hold. `pc_en` is ignored.
5. **HALT**
   - PC holds; no new capture.
   - A pending `id_valid` stays until `fire`, then clears.
   - Exits only by a legal redirect (an older in-flight branch) or by `rst`.
6. **ERR**
   - Terminal until `rst`. `redirect` is ignored.
   - `id_valid`=0, PC frozen.

Range check in RUN: if PC > `IMEM_BYTES`-4 or PC[1:0]≠0 when a capture would occur, go to ERR and set `fetch_err` instead of capturing.

`halted` = (state==HALT). `fetch_err` = (state==ERR).

## Timing
Reset values:
- PC = `RESET_PC`, so `addr` = `RESET_PC`.
- `id_valid`=0, `id_inst`=0, `id_pc`=0.
- `halted`=0, `fetch_err`=0.

Reset has priority over every other input. Asserting it mid-stall, mid-HALT or in ERR returns to the reset state on the next edge.

Latency and throughput:
- `addr` is registered. `inst_in` is sampled in the same cycle.
- The instruction at PC appears on `id_inst`/`id_pc` with `id_valid`=1 one cycle after `addr`=PC.
- Throughput is one instruction per cycle while `id_ready`=1.

Redirect:
- The cycle after `redirect`: `addr`=`redirect_pc` and `id_valid`=0.
- The first target instruction is valid one further cycle later (1 bubble).

Handshake rules:
- While `id_valid`=1 and `id_ready`=0, `id_inst`/`id_pc` are stable.
- `id_valid` never drops without `fire`, except on redirect/ERR flush or `rst`.

Halt: `halted` rises one cycle after the cycle in which `addr` points at the zero word.

## Test plan
- **Straight line**
  - Stimulus: memory holds 00900513, 00600593, 00b50633, 40b506b3, 00d67733, 00000000 at 0x00..0x14; `id_ready`=1.
  - Required: `id_pc` 0,4,8,C,10 on consecutive cycles with the matching `id_inst`.
  - Then: `halted`=1 with `addr`=0x14, and `id_valid`=0 after the last fire.
- **Backpressure**
  - Stimulus: drop `id_ready` for 3 cycles while `id_inst`=00b50633 (PC 8).
  - Required: `id_inst`, `id_pc` and `addr` (0xC) hold. Flow resumes with PC 0xC next, with no loss or duplication.
- **Redirect**
  - Stimulus: pulse `redirect` with `redirect_pc`=0x4 while `id_pc`=0x8.
  - Required: next cycle `addr`=0x4 and `id_valid`=0; the cycle after, `id_inst`=00600593.
- **Redirect out of HALT, and simultaneous redirect/halt**
  - Stimulus: with `halted`=1, redirect to 0x0. Separately, assert redirect in the same cycle `pc_en`=0.
  - Required: in both cases the block resumes in RUN at the target and `halted`=0.
- **Errors**
  - Stimulus: redirect to 0x6, and separately redirect to 0x400 with `IMEM_BYTES`=1024.
  - Required: `fetch_err`=1 and `id_valid`=0; a later redirect has no effect.
- **Reset mid-operation**
  - Stimulus: assert `rst` during a stall with `id_valid`=1.
  - Required: next edge `addr`=`RESET_PC` and all outputs at their reset values.
